// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    localparam int SA_MIN_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; `sub` exists only with SERIAL_ADDER_SUB_EN.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, carry
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit combinational full adder; the serial datapath reuses it every cycle.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin, LSB first, one bit per clock.
// Optional subtract mode via SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < SA_MIN_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH must be >= %0d", SA_MIN_WIDTH);
    end

    sa_state_t        state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, s_q, sum_q;
    logic             c_q, carry_q;
    logic [CW-1:0]    cnt_q;
    logic             load, last;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;

    full_adder_bit u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Subtract is a + ~b + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = bus.sub ? ~bus.b : bus.b;
    assign c_ld = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_ld = bus.b;
    assign c_ld = bus.cin;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = (state == ST_RUN) && (cnt_q == CNT_LAST);
        case (state)
            ST_IDLE: if (bus.start) begin
                load      = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN:  if (last) state_nxt = ST_DONE;
            ST_DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_q   <= bus.a;
                b_q   <= b_ld;
                c_q   <= c_ld;
                cnt_q <= '0;
            end else if (state == ST_RUN) begin
                s_q <= {fa_s, s_q[WIDTH-1:1]};
                a_q <= {1'b0, a_q[WIDTH-1:1]};
                b_q <= {1'b0, b_q[WIDTH-1:1]};
                c_q <= fa_co;
                // Counter parks at the last index instead of wrapping.
                if (last) begin
                    sum_q   <= {fa_s, s_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder with a start/done handshake. It computes `a + b + cin` for `WIDTH`-bit operands one bit per clock, LSB first, using a single full-adder cell and a registered carry. It succeeds the team's single-bit combinational adder cells and targets datapaths that trade throughput for area.

## Interface
- `WIDTH`, default 8: operand and result width; legal range `WIDTH >= 2`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request; sampled only when the FSM is in IDLE or DONE.
- `a`  in  WIDTH: operand A; captured on an accepted `start`.
- `b`  in  WIDTH: operand B; captured on an accepted `start`.
- `cin`  in  1: carry-in; captured on an accepted `start`.
- `sub`  in  1: subtract mode; present only with `SERIAL_ADDER_SUB_EN`; captured on an accepted `start`.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse when a new result is valid.
- `sum`  out  WIDTH: registered result; holds its value until the next completion.
- `carry`  out  1: registered carry-out of the MSB; holds with `sum`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, with `start`=1: load shift registers `A<=a`, `B<=b`, carry register `c<=cin`, bit counter `cnt<=0`; go to RUN.
- RUN, each edge:
  - Full-adder on `A[0]`, `B[0]`, `c`.
  - Shift the sum bit into the MSB of the internal sum shift register.
  - Shift `A` and `B` right by one.
  - Update `c` with the carry-out.
  - Increment `cnt`.
- RUN, on the edge where `cnt==WIDTH-1`:
  - Copy the completed sum shift register to `sum`.
  - Copy the final carry to `carry`.
  - Go to DONE.
- DONE lasts one cycle. `start`=1 loads new operands and goes to RUN. Otherwise the FSM returns to IDLE.
- `start` in RUN is ignored: no queueing, no abort, and operands are not re-sampled.
- `busy` = (state==RUN). `done` = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Arithmetic: the result is `{carry,sum} = a + b + cin`, modulo 2^(WIDTH+1).
- `cnt` width is `$clog2(WIDTH)`. `cnt` resets to 0 and never wraps past `WIDTH-1` within one operation.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `carry`=0. Internal shift registers, `c` and `cnt` also reset to 0.
- Latency, with `start` accepted at edge 0:
  - `busy` is high for exactly `WIDTH` cycles, from edge 0 to edge `WIDTH`.
  - `sum`, `carry` and `done` become visible after edge `WIDTH`.
  - `done` is high for exactly one cycle.
- Throughput: one result every `WIDTH+1` cycles in the back-to-back case, with `start` held or re-asserted during DONE.
- Reset mid-RUN takes effect on the next edge:
  - Any reset aborts the operation and returns to IDLE.
  - No `done` pulse is produced.
  - `sum` and `carry` clear to 0.
- `start` and `rst` in the same cycle: reset wins.

## Configuration
- The macro `SERIAL_ADDER_SUB_EN` controls the `sub` port.
- Defined: the `sub` port exists.
  - With `sub`=1 at capture, the block loads `B<=~b` and `c<=1`, and `cin` is ignored.
  - The result is `a - b` modulo 2^WIDTH.
  - `carry`=1 means no borrow (a >= b, unsigned).
  - With `sub`=0, behaviour is identical to add mode.
- Undefined: the `sub` port and its logic are absent, and the block only adds.

## Structure
- Shared package `serial_adder_pkg` holds:
  - The state typedef (IDLE/RUN/DONE, 2-bit encoding 0/1/2).
  - The localparam for the minimum legal `WIDTH`.
- One sub-module, `full_adder_bit`:
  - Inputs `x`, `y`, `ci`; outputs `s`, `co`.
  - Purely combinational.
  - Instantiated once; the serial datapath wraps it with registers.

## Test plan
- Basic add:
  - Stimulus: `WIDTH`=8, `a`=0x3C, `b`=0x5A, `cin`=0, one-cycle `start`.
  - Response: `busy` high for 8 cycles, then `done` pulses once with `sum`=0x96 and `carry`=0.
- Overflow and carry-in:
  - Stimulus 1: `a`=0xFF, `b`=0x01, `cin`=0. Response: `sum`=0x00, `carry`=1.
  - Stimulus 2: `a`=0xFF, `b`=0x00, `cin`=1. Response: `sum`=0x00, `carry`=1.
- Ignored start:
  - Stimulus: start `a`=0x01, `b`=0x02, then pulse `start` with `a`=0x80, `b`=0x80 during cycle 3 of RUN.
  - Response: the result is `sum`=0x03 and `carry`=0, with exactly one `done`.
- Back-to-back:
  - Stimulus: `start` held high continuously with `a`=0x10, `b`=0x22.
  - Response: `done` pulses every 9 cycles, each time with `sum`=0x32.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle at RUN cycle 4.
  - Response: no `done`; `busy`, `sum` and `carry` are 0 on the next cycle; the next `start` computes correctly.
- Subtract (`SERIAL_ADDER_SUB_EN` defined):
  - Stimulus 1: `a`=0x10, `b`=0x20, `sub`=1. Response: `sum`=0xF0, `carry`=0.
  - Stimulus 2: `a`=0x20, `b`=0x10, `sub`=1. Response: `sum`=0x10, `carry`=1.
